pcie_cfg_mgmt_responder: RTL

Target side of the PCIe configuration-management port: accepts cfg_mgmt read/write strobes from the example core and completes them against a per-function dword register file with a fixed, parameterised latency. It stands in for the hard IP configuration space in loopback builds and simulation benches, so the core's cfg_mgmt initiator can be exercised without a PCIe block instance.

---
 rtl/pcie_cfg_mgmt_responder.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/pcie_cfg_mgmt_responder.sv
// rtl/pcie_cfg_mgmt_responder.sv - cfg_mgmt target with per-function dword register file and fixed response latency
//
// Purpose: completes cfg_mgmt read/write strobes against a FUNC_COUNT x REG_COUNT
// dword register file, RESP_LATENCY cycles after acceptance. Dword 0 of every
// function is the read-only ID_VALUE; addresses at or beyond REG_COUNT read 0 and
// drop writes; bad function numbers or read+write together are rejected.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cfg_mgmt_addr[9:0]             dword address
//   cfg_mgmt_function_number[7:0]  target function
//   cfg_mgmt_write / _write_data / _byte_enable   write request, held until done
//   cfg_mgmt_read                  read request, held until done
//   cfg_mgmt_read_data[31:0]       read result, zero unless done is high
//   cfg_mgmt_read_write_done       one-cycle completion pulse
//   err_unsupported                one-cycle pulse with done for rejected requests
module pcie_cfg_mgmt_responder #(
    parameter int          FUNC_COUNT   = 2,
    parameter int          REG_COUNT    = 64,
    parameter int          RESP_LATENCY = 4,
    parameter logic [31:0] ID_VALUE     = 32'h10EE9038
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  cfg_mgmt_addr,
    input  logic [7:0]  cfg_mgmt_function_number,
    input  logic        cfg_mgmt_write,
    input  logic [31:0] cfg_mgmt_write_data,
    input  logic [3:0]  cfg_mgmt_byte_enable,
    input  logic        cfg_mgmt_read,
    output logic [31:0] cfg_mgmt_read_data,
    output logic        cfg_mgmt_read_write_done,
    output logic        err_unsupported
);

    localparam int AW    = $clog2(REG_COUNT);
    localparam int FW    = (FUNC_COUNT > 1) ? $clog2(FUNC_COUNT) : 1;
    localparam int DEPTH = FUNC_COUNT * REG_COUNT;
    localparam int IW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_HOLD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        accept;
    logic        enter_done;

    // Request fields captured at acceptance
    logic          rd_q;
    logic          wr_q;
    logic          reject_q;
    logic          oor_q;
    logic          id_q;
    logic [FW-1:0] fn_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;

    // Live classification of the strobes presented in IDLE
    logic live_reject;
    logic live_oor;
    logic live_id;

    // Fields used at the DONE-entry edge. With RESP_LATENCY=1 that edge is the
    // acceptance edge itself, so the live inputs are used instead of the latches.
    logic          cur_rd;
    logic          cur_wr;
    logic          cur_reject;
    logic          cur_oor;
    logic          cur_id;
    logic [FW-1:0] cur_fn;
    logic [AW-1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [3:0]    cur_be;
    logic [IW-1:0] idx;
    logic          storable;

    logic [31:0] regs [DEPTH];
    logic [31:0] rdata_q;
    logic        err_q;

    always_comb begin
        live_reject = (cfg_mgmt_read & cfg_mgmt_write)
                    | (cfg_mgmt_function_number >= 8'(FUNC_COUNT));
        // Range check on the full 10-bit address before any truncation
        live_oor    = ({1'b0, cfg_mgmt_addr} >= 11'(REG_COUNT));
        live_id     = (cfg_mgmt_addr == 10'd0);
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_mgmt_read || cfg_mgmt_write) begin
                    accept     = 1'b1;
                    cnt_next   = 4'(RESP_LATENCY - 1);
                    state_next = (RESP_LATENCY == 1) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                // The count reaches zero on the same edge that enters DONE
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_HOLD;
            S_HOLD:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            reject_q <= 1'b0;
            oor_q    <= 1'b0;
            id_q     <= 1'b0;
            fn_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
        end else if (accept) begin
            rd_q     <= cfg_mgmt_read;
            wr_q     <= cfg_mgmt_write;
            reject_q <= live_reject;
            oor_q    <= live_oor;
            id_q     <= live_id;
            fn_q     <= cfg_mgmt_function_number[FW-1:0];
            addr_q   <= cfg_mgmt_addr[AW-1:0];
            wdata_q  <= cfg_mgmt_write_data;
            be_q     <= cfg_mgmt_byte_enable;
        end
    end

    always_comb begin
        if (state == S_IDLE) begin
            cur_rd     = cfg_mgmt_read;
            cur_wr     = cfg_mgmt_write;
            cur_reject = live_reject;
            cur_oor    = live_oor;
            cur_id     = live_id;
            cur_fn     = cfg_mgmt_function_number[FW-1:0];
            cur_addr   = cfg_mgmt_addr[AW-1:0];
            cur_wdata  = cfg_mgmt_write_data;
            cur_be     = cfg_mgmt_byte_enable;
        end else begin
            cur_rd     = rd_q;
            cur_wr     = wr_q;
            cur_reject = reject_q;
            cur_oor    = oor_q;
            cur_id     = id_q;
            cur_fn     = fn_q;
            cur_addr   = addr_q;
            cur_wdata  = wdata_q;
            cur_be     = be_q;
        end
        idx        = IW'(32'(cur_fn) * 32'(REG_COUNT) + 32'(cur_addr));
        storable   = !cur_reject && !cur_oor && !cur_id;
        enter_done = (state_next == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (enter_done && cur_wr && storable) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) begin
                    regs[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data is sampled on the DONE-entry edge, before this transaction's
    // own commit (a transaction is never both a legal read and a legal write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_done) begin
            err_q <= cur_reject;
            if (cur_reject) begin
                rdata_q <= 32'hFFFF_FFFF;
            end else if (!cur_rd || cur_oor) begin
                rdata_q <= 32'd0;
            end else if (cur_id) begin
                rdata_q <= ID_VALUE;
            end else begin
                rdata_q <= regs[idx];
            end
        end
    end

    assign cfg_mgmt_read_write_done = (state == S_DONE);
    assign cfg_mgmt_read_data       = cfg_mgmt_read_write_done ? rdata_q : 32'd0;
    assign err_unsupported          = cfg_mgmt_read_write_done & err_q;

endmodule
